// File: rtl/accelerator_lstm_vector_feeder.sv
// Vector feeder: the host preloads one vector into a local buffer, and the block replays it
// element by element in answer to controller requests after each START.
module accelerator_lstm_vector_feeder #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 64,
  parameter int ADDR_SIZE = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOAD_CLEAR,
  input  logic                 LOAD_ENABLE,
  input  logic [DATA_SIZE-1:0] LOAD_DATA,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic                 START,
  output logic                 READY,
  input  logic                 X_OUT_ENABLE,
  output logic                 X_IN_ENABLE,
  output logic [DATA_SIZE-1:0] X_IN,
  output logic [ADDR_SIZE:0]   COUNT,
  output logic                 FULL,
  output logic                 ERROR
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [ADDR_SIZE:0] LP_DEPTH = (ADDR_SIZE+1)'(DEPTH);

  state_t               r_state, w_state_next;
  logic [DATA_SIZE-1:0] r_buf [DEPTH];
  logic [ADDR_SIZE:0]   r_count;
  logic [ADDR_SIZE:0]   r_rd_ptr;
  logic [ADDR_SIZE:0]   r_size;
  logic [DATA_SIZE-1:0] r_x_in;
  logic                 r_x_in_en;
  logic                 r_ready;
  logic                 r_error;

  logic                 w_idle, w_full, w_size_ok, w_start_go;
  logic                 w_load_wr, w_req, w_last, w_err;
  logic [DATA_SIZE-1:0] w_count_ext;

  // SIZE_IN is compared at full width so oversized requests can't alias onto a valid length
  assign w_count_ext = DATA_SIZE'(r_count);
  assign w_idle      = (r_state == S_IDLE);
  assign w_full      = (r_count == LP_DEPTH);
  assign w_size_ok   = (SIZE_IN != '0) && (SIZE_IN <= w_count_ext);
  assign w_start_go  = w_idle && START && w_size_ok;
  assign w_load_wr   = w_idle && LOAD_ENABLE && !LOAD_CLEAR && !w_full;
  assign w_req       = !w_idle && X_OUT_ENABLE;
  assign w_last      = w_req && (r_rd_ptr == r_size - 1'b1);
  assign w_err       = (w_idle && LOAD_ENABLE && !LOAD_CLEAR && w_full)
                     || (!w_idle && LOAD_ENABLE)
                     || (w_idle && START && !w_size_ok)
                     || (w_idle && X_OUT_ENABLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_go) w_state_next = S_STREAM;
      S_STREAM: if (w_last)     w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_size    <= '0;
      r_x_in    <= '0;
      r_x_in_en <= 1'b0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_x_in_en <= w_req;
      r_ready   <= w_last;
      r_error   <= w_err;
      if (w_req) begin
        r_x_in   <= r_buf[r_rd_ptr[ADDR_SIZE-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_start_go) begin
        r_rd_ptr <= '0;
        r_size   <= SIZE_IN[ADDR_SIZE:0];
      end
      if (w_idle && LOAD_CLEAR) r_count <= '0;
      else if (w_load_wr)       r_count <= r_count + 1'b1;
    end
  end

  // Buffer storage carries no reset; contents persist across runs and clears
  always_ff @(posedge CLK) begin
    if (w_load_wr) r_buf[r_count[ADDR_SIZE-1:0]] <= LOAD_DATA;
  end

  assign READY       = r_ready;
  assign X_IN_ENABLE = r_x_in_en;
  assign X_IN        = r_x_in;
  assign COUNT       = r_count;
  assign FULL        = w_full;
  assign ERROR       = r_error;

endmodule

// File: tb/tb_accelerator_lstm_vector_feeder.sv
// Bench for the vector feeder: directed and random steps, each cycle checked against a
// queue-based model of the buffer and the stream in flight.
module tb_accelerator_lstm_vector_feeder;
  localparam int DATA_SIZE = 64;
  localparam int DEPTH     = 64;
  localparam int ADDR_SIZE = 6;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b0;
  logic                 LOAD_CLEAR = 1'b0;
  logic                 LOAD_ENABLE = 1'b0;
  logic [DATA_SIZE-1:0] LOAD_DATA = '0;
  logic [DATA_SIZE-1:0] SIZE_IN = '0;
  logic                 START = 1'b0;
  logic                 READY;
  logic                 X_OUT_ENABLE = 1'b0;
  logic                 X_IN_ENABLE;
  logic [DATA_SIZE-1:0] X_IN;
  logic [ADDR_SIZE:0]   COUNT;
  logic                 FULL;
  logic                 ERROR;

  accelerator_lstm_vector_feeder #(
    .DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE)
  ) dut (
    .CLK(CLK), .RST(RST), .LOAD_CLEAR(LOAD_CLEAR), .LOAD_ENABLE(LOAD_ENABLE),
    .LOAD_DATA(LOAD_DATA), .SIZE_IN(SIZE_IN), .START(START), .READY(READY),
    .X_OUT_ENABLE(X_OUT_ENABLE), .X_IN_ENABLE(X_IN_ENABLE), .X_IN(X_IN),
    .COUNT(COUNT), .FULL(FULL), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: loaded vector as a queue, plus the elements still owed to the current stream
  logic [63:0] m_buf[$];
  logic [63:0] m_q[$];
  bit          m_stream = 1'b0;
  logic [63:0] e_x = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit e_en, input bit e_rdy, input bit e_err);
    chk("x_in_enable", {63'd0, X_IN_ENABLE}, {63'd0, e_en});
    chk("x_in", X_IN, e_x);
    chk("ready", {63'd0, READY}, {63'd0, e_rdy});
    chk("error", {63'd0, ERROR}, {63'd0, e_err});
    chk("count", 64'(COUNT), 64'(m_buf.size()));
    chk("full", {63'd0, FULL}, {63'd0, m_buf.size() == DEPTH});
  endtask

  task automatic cyc(input bit clr, input bit ld, input logic [63:0] d,
                     input logic [63:0] sz, input bit st, input bit rq);
    bit e_en, e_rdy, e_err;
    int n0;
    logic [63:0] snap[$];
    LOAD_CLEAR = clr; LOAD_ENABLE = ld; LOAD_DATA = d;
    SIZE_IN = sz; START = st; X_OUT_ENABLE = rq;
    e_en = 0; e_rdy = 0; e_err = 0;
    if (!m_stream) begin
      n0 = m_buf.size();
      snap = m_buf;
      if (rq) e_err = 1;
      if (clr) m_buf.delete();
      else if (ld) begin
        if (n0 == DEPTH) e_err = 1;
        else m_buf.push_back(d);
      end
      if (st) begin
        if (sz == 0 || sz > 64'(n0)) e_err = 1;
        else begin
          m_q.delete();
          for (int i = 0; i < int'(sz); i++) m_q.push_back(snap[i]);
          m_stream = 1;
        end
      end
    end else begin
      if (ld) e_err = 1;
      if (rq) begin
        e_en = 1;
        e_x = m_q.pop_front();
        if (m_q.size() == 0) begin
          e_rdy = 1;
          m_stream = 0;
        end
      end
    end
    @(posedge CLK);
    #1;
    check_outputs(e_en, e_rdy, e_err);
  endtask

  task automatic idle();
    cyc(0, 0, 64'd0, 64'd0, 0, 0);
  endtask

  task automatic load(input logic [63:0] d);
    cyc(0, 1, d, 64'd0, 0, 0);
  endtask

  task automatic start(input logic [63:0] sz);
    cyc(0, 0, 64'd0, sz, 1, 0);
  endtask

  task automatic req();
    cyc(0, 0, 64'd0, 64'd0, 0, 1);
  endtask

  initial begin
    // Reset state
    @(posedge CLK);
    #2;
    check_outputs(0, 0, 0);
    #6 RST = 1'b1;

    // Load 1..4 and stream all four back to back, then a late request
    for (int i = 1; i <= 4; i++) load(64'(i));
    start(64'd4);
    for (int i = 0; i < 4; i++) req();
    req();
    idle();

    // Replay two elements with spaced requests; X_IN holds afterwards
    start(64'd2);
    req(); idle(); idle();
    req(); idle(); idle();

    // Rejected STARTs: too long, zero, and beyond DEPTH at full width
    start(64'd5); idle();
    start(64'd0); idle();
    start(64'h1_0000_0004); idle();

    // START with a simultaneous request, loads/clears/STARTs during streaming
    cyc(0, 0, 64'd0, 64'd3, 1, 1);
    req();
    cyc(0, 1, 64'hdead, 64'd0, 0, 0);
    cyc(1, 0, 64'd0, 64'd1, 1, 1);
    req();
    idle();

    // Fill to DEPTH, overflow, replay the whole buffer, then clear with load
    cyc(1, 0, 64'd0, 64'd0, 0, 0);
    for (int i = 0; i < DEPTH; i++) load({$urandom, $urandom});
    load(64'hffff_0000_ffff_0000);
    start(64'd64);
    for (int i = 0; i < DEPTH; i++) req();
    cyc(1, 1, 64'h55, 64'd0, 0, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, {$urandom, $urandom},
          64'($urandom_range(0, m_buf.size() + 1)), $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < DEPTH + 2; i++) req();

    // Reset in the middle of a stream
    cyc(1, 0, 64'd0, 64'd0, 0, 0);
    for (int i = 1; i <= 4; i++) load(64'(i * 16));
    start(64'd4);
    req(); req();
    #2 RST = 1'b0;
    #1;
    m_buf.delete(); m_q.delete(); m_stream = 0; e_x = '0;
    check_outputs(0, 0, 0);
    @(posedge CLK);
    #3 RST = 1'b1;
    req();
    idle();
    load(64'h77); start(64'd1); req(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
